// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads to instruction memory and
// buffers returned words, tagged with their PC, in an in-order queue for the decode stage.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic        funct7_5,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halted,
  output logic        misaligned_pc
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(FIFO_DEPTH - 1);
  localparam logic [CntW:0]   DepthCnt = (CntW + 1)'(FIFO_DEPTH);
  localparam logic [31:0]     Nop = 32'h0000_0013;

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            misaligned_q, misaligned_d;
  logic [CntW-1:0] inflight_q, inflight_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic [CntW-1:0] count_q, count_d;

  // Instruction queue storage and pointers
  logic [31:0]     q_instr_q [FIFO_DEPTH];
  logic [31:0]     q_pc_q    [FIFO_DEPTH];
  logic [PtrW-1:0] q_rd_q, q_rd_d;
  logic [PtrW-1:0] q_wr_q, q_wr_d;

  // PCs of accepted requests, popped one per response (dropped or not)
  logic [31:0]     pend_pc_q [FIFO_DEPTH];
  logic [PtrW-1:0] pend_rd_q, pend_rd_d;
  logic [PtrW-1:0] pend_wr_q, pend_wr_d;

  logic            pop;
  logic            accept;
  logic            drop_resp;
  logic            push;
  logic [CntW:0]   occupancy;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastIdx) ? '0 : p + PtrW'(1);
  endfunction

  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid & instr_ready;

  // Slots already claimed by in-flight requests and queued words, net of this cycle's pop
  assign occupancy = {1'b0, inflight_q} + {1'b0, count_q} - {{CntW{1'b0}}, pop};

  assign imem_req_valid = !reset && !halted && !redirect && !misaligned_q &&
                          (occupancy < DepthCnt);
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid & imem_req_ready;

  assign drop_resp = imem_resp_valid & (drop_q != '0);
  // A response landing in a redirect cycle belongs to the abandoned path
  assign push      = imem_resp_valid & !drop_resp & !redirect;

  assign instr         = instr_valid ? q_instr_q[q_rd_q] : Nop;
  assign instr_pc      = instr_valid ? q_pc_q[q_rd_q] : 32'h0000_0000;
  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7_5      = instr[30];
  assign misaligned_pc = misaligned_q;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    misaligned_d = misaligned_q;
    if (redirect) begin
      fetch_pc_d   = redirect_pc;
      misaligned_d = |redirect_pc[1:0];
    end else if (accept) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    pend_wr_d  = pend_wr_q;
    pend_rd_d  = pend_rd_q;
    if (accept) begin
      inflight_d = inflight_d + CntW'(1);
      pend_wr_d  = ptr_inc(pend_wr_q);
    end
    if (imem_resp_valid) begin
      inflight_d = inflight_d - CntW'(1);
      pend_rd_d  = ptr_inc(pend_rd_q);
    end
  end

  // No request is accepted in a redirect cycle, so everything still in flight is stale
  always_comb begin
    drop_d = drop_q;
    if (redirect) begin
      drop_d = inflight_d;
    end else if (drop_resp) begin
      drop_d = drop_q - CntW'(1);
    end
  end

  always_comb begin
    q_rd_d  = q_rd_q;
    q_wr_d  = q_wr_q;
    count_d = count_q;
    if (redirect) begin
      q_rd_d  = q_wr_q;
      count_d = '0;
    end else begin
      if (pop) begin
        q_rd_d = ptr_inc(q_rd_q);
      end
      if (push) begin
        q_wr_d = ptr_inc(q_wr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q   <= RESET_PC;
      misaligned_q <= 1'b0;
      inflight_q   <= '0;
      drop_q       <= '0;
      count_q      <= '0;
      q_rd_q       <= '0;
      q_wr_q       <= '0;
      pend_rd_q    <= '0;
      pend_wr_q    <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      misaligned_q <= misaligned_d;
      inflight_q   <= inflight_d;
      drop_q       <= drop_d;
      count_q      <= count_d;
      q_rd_q       <= q_rd_d;
      q_wr_q       <= q_wr_d;
      pend_rd_q    <= pend_rd_d;
      pend_wr_q    <= pend_wr_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the counters and pointers
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_pc_q[pend_wr_q] <= fetch_pc_q;
    end
    if (push) begin
      q_instr_q[q_wr_q] <= imem_resp_data;
      q_pc_q[q_wr_q]    <= pend_pc_q[pend_rd_q];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written corner sequences and
// a randomized run against an epoch-based reference model with a randomized memory.
module tb_fetch_unit;

  localparam int unsigned Depth   = 2;
  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halted;
  logic        misaligned_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC  (ResetPc),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7_5       (funct7_5),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .misaligned_pc  (misaligned_pc)
  );

  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // ---------------- memory: in-order, random latency >= 1, random ready ----------------
  logic        mem_hold  = 1'b0;
  int unsigned lat_extra = 0;
  int unsigned ready_pct = 100;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];

  initial begin
    logic        acc;
    logic [31:0] acc_addr;
    int          mcyc;
    acc = 1'b0;
    acc_addr = '0;
    mcyc = 0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      acc = 1'b0;
      if (reset) begin
        mq.delete();
      end else begin
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        if (imem_resp_valid && mq.size() > 0) void'(mq.pop_front());
      end
      @(posedge clk);
      #2;
      mcyc++;
      if (acc) mq.push_back('{addr: acc_addr, due: mcyc + int'($urandom_range(lat_extra, 0))});
      imem_req_ready = ($urandom_range(99, 0) < ready_pct);
      if (!reset && !mem_hold && mq.size() > 0 && mq[0].due <= mcyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mq[0].addr);
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
      end
    end
  end

  // ---------------- reference model: requests tagged with a redirect epoch ----------------
  typedef struct { logic [31:0] pc; int ep; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  pend_t       pq[$];
  ent_t        iq[$];
  int          epoch = 0;
  logic [31:0] m_pc  = ResetPc;
  logic        m_mis = 1'b0;
  int          cyc   = 0;

  task automatic model_step();
    int          npop;
    logic        e_rv;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    pend_t       p;
    cyc++;
    tests++;
    if (reset) begin
      if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || misaligned_pc !== 1'b0) begin
        fails++;
        $display("FAIL reset_outputs cyc %0d: req_valid=%b instr_valid=%b misaligned=%b, required 0",
                 cyc, imem_req_valid, instr_valid, misaligned_pc);
      end
      pq.delete();
      iq.delete();
      m_pc  = ResetPc;
      m_mis = 1'b0;
      return;
    end
    npop    = (iq.size() > 0 && instr_ready) ? 1 : 0;
    e_rv    = !halted && !redirect && !m_mis && (pq.size() + iq.size() - npop < int'(Depth));
    e_iv    = iq.size() > 0;
    e_instr = e_iv ? iq[0].data : 32'h0000_0013;
    e_pc    = e_iv ? iq[0].pc : 32'h0;
    if (imem_req_valid !== e_rv || (e_rv && imem_req_addr !== m_pc) || instr_valid !== e_iv ||
        instr !== e_instr || instr_pc !== e_pc || opcode !== e_instr[6:0] ||
        funct3 !== e_instr[14:12] || funct7_5 !== e_instr[30] || misaligned_pc !== m_mis) begin
      fails++;
      $display("FAIL model cyc %0d: got rv=%b addr=%h iv=%b instr=%h pc=%h op=%h f3=%h f7=%b mis=%b, required rv=%b addr=%h iv=%b instr=%h pc=%h mis=%b",
               cyc, imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, opcode, funct3,
               funct7_5, misaligned_pc, e_rv, m_pc, e_iv, e_instr, e_pc, m_mis);
    end
    if (npop == 1) void'(iq.pop_front());
    if (imem_resp_valid) begin
      if (pq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_resp cyc %0d: response with no request outstanding", cyc);
      end else begin
        p = pq.pop_front();
        if (p.ep == epoch && !redirect) begin
          iq.push_back('{pc: p.pc, data: mem_word(p.pc)});
          if (iq.size() > int'(Depth)) begin
            fails++;
            $display("FAIL queue_overflow cyc %0d: occupancy %0d, required <= %0d",
                     cyc, iq.size(), Depth);
          end
        end
      end
    end
    if (e_rv && imem_req_ready) begin
      pq.push_back('{pc: m_pc, ep: epoch});
      m_pc = m_pc + 32'd4;
    end
    if (redirect) begin
      iq.delete();
      epoch++;
      m_pc  = redirect_pc;
      m_mis = |redirect_pc[1:0];
    end
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic rd, input logic [31:0] rpc, input logic h);
    instr_ready = ir;
    redirect    = rd;
    redirect_pc = rpc;
    halted      = h;
    #3;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        ir;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int          found;
    logic        h;
    logic [31:0] rpc;
    logic [31:0] exp_instr;

    reset = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; halted = 1'b0;
    tbl[0] = '{ir: 1'b0, rv: 1'b1, addr: 32'h0,  iv: 1'b0, pc: 32'h0};
    tbl[1] = '{ir: 1'b0, rv: 1'b1, addr: 32'h4,  iv: 1'b0, pc: 32'h0};
    tbl[2] = '{ir: 1'b0, rv: 1'b0, addr: 32'h0,  iv: 1'b1, pc: 32'h0};
    tbl[3] = '{ir: 1'b0, rv: 1'b0, addr: 32'h0,  iv: 1'b1, pc: 32'h0};
    tbl[4] = '{ir: 1'b1, rv: 1'b1, addr: 32'h8,  iv: 1'b1, pc: 32'h0};
    tbl[5] = '{ir: 1'b1, rv: 1'b1, addr: 32'hC,  iv: 1'b1, pc: 32'h4};
    tbl[6] = '{ir: 1'b1, rv: 1'b1, addr: 32'h10, iv: 1'b1, pc: 32'h8};
    tbl[7] = '{ir: 1'b0, rv: 1'b0, addr: 32'h0,  iv: 1'b1, pc: 32'hC};

    @(posedge clk);
    #1;
    chk("reset_req_valid", 32'(imem_req_valid), 32'h0);
    chk("reset_instr_nop", instr, 32'h0000_0013);
    tick();
    tick();
    reset = 1'b0;

    // Reset release, 1-cycle memory; decode stalled until two words queued
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].ir, 1'b0, 32'h0, 1'b0);
      exp_instr = tbl[i].iv ? mem_word(tbl[i].pc) : 32'h0000_0013;
      chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].rv));
      if (tbl[i].rv) chk($sformatf("vec%0d_req_addr", i), imem_req_addr, tbl[i].addr);
      chk($sformatf("vec%0d_instr_valid", i), 32'(instr_valid), 32'(tbl[i].iv));
      chk($sformatf("vec%0d_instr_pc", i), instr_pc, tbl[i].iv ? tbl[i].pc : 32'h0);
      chk($sformatf("vec%0d_instr", i), instr, exp_instr);
      if (i == 2) begin
        chk("vec2_opcode", 32'(opcode), 32'h13);
        chk("vec2_funct3", 32'(funct3), 32'h0);
      end
      tick();
    end

    // Redirect with two requests (0x8, 0xC) held in flight
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      tick();
    end
    mem_hold = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("redir_req_c_addr", imem_req_addr, 32'hC);
    tick();
    drive(1'b1, 1'b1, 32'h100, 1'b0);
    chk("redir_cycle_no_req", 32'(imem_req_valid), 32'h0);
    tick();
    mem_hold = 1'b0;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      if (imem_req_valid) begin found = 1; break; end
      tick();
    end
    chk("redir_req_seen", found, 1);
    chk("redir_req_addr", imem_req_addr, 32'h100);
    tick();
    found = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      if (instr_valid) begin found = 1; break; end
      tick();
    end
    chk("redir_instr_seen", found, 1);
    chk("redir_first_pc", instr_pc, 32'h100);
    chk("redir_first_instr", instr, mem_word(32'h100));
    tick();

    // Misaligned redirect, drain, then aligned redirect recovers
    drive(1'b1, 1'b1, 32'h102, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("mis_set", 32'(misaligned_pc), 32'h1);
    chk("mis_no_req", 32'(imem_req_valid), 32'h0);
    tick();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("mis_drained", 32'(instr_valid), 32'h0);
    chk("mis_still_no_req", 32'(imem_req_valid), 32'h0);
    tick();
    drive(1'b1, 1'b1, 32'h200, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("mis_cleared", 32'(misaligned_pc), 32'h0);
    chk("mis_resume_valid", 32'(imem_req_valid), 32'h1);
    chk("mis_resume_addr", imem_req_addr, 32'h200);
    tick();

    // Async reset clears a sticky misaligned flag
    drive(1'b0, 1'b1, 32'h3, 1'b0);
    tick();
    instr_ready = 1'b0; redirect = 1'b0;
    #2 reset = 1'b1;
    #1 chk("async_reset_mis", 32'(misaligned_pc), 32'h0);
    tick(); tick(); reset = 1'b0;

    // Async reset with two entries queued
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      tick();
    end
    #1 chk("full_instr_valid", 32'(instr_valid), 32'h1);
    chk("full_no_req", 32'(imem_req_valid), 32'h0);
    #1 reset = 1'b1;
    #1 chk("async_reset_iv", 32'(instr_valid), 32'h0);
    chk("async_reset_rv", 32'(imem_req_valid), 32'h0);
    tick(); tick(); reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("post_reset_addr", imem_req_addr, ResetPc);
    chk("post_reset_valid", 32'(imem_req_valid), 32'h1);
    tick();

    // Halt with 0x10 in flight, then resume at 0x14
    found = 0;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      if (imem_req_valid && imem_req_ready && imem_req_addr == 32'h10) begin found = 1; break; end
      tick();
    end
    chk("halt_setup", found, 1);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("halt_no_req", 32'(imem_req_valid), 32'h0);
    tick();
    found = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      if (instr_valid && instr_pc == 32'h10) begin found = 1; break; end
      tick();
    end
    chk("halt_resp_delivered", found, 1);
    chk("halt_still_no_req", 32'(imem_req_valid), 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("halt_resume_valid", 32'(imem_req_valid), 32'h1);
    chk("halt_resume_addr", imem_req_addr, 32'h14);
    tick();

    // PC wraps past the top of the address space
    drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("wrap_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("wrap_addr_zero", imem_req_addr, 32'h0);
    tick();

    // Randomized traffic against the reference model
    ready_pct = 70;
    lat_extra = 3;
    h = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(19, 0) == 0) h = ~h;
      rpc = $urandom;
      rpc[1:0] = ($urandom_range(7, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      mem_hold = ($urandom_range(9, 0) == 0);
      drive($urandom_range(3, 0) != 0, $urandom_range(24, 0) == 0, rpc, h);
      tick();
    end
    mem_hold = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
